// File: rtl/serial_uart_endpoint_pkg.sv
// serial_uart_endpoint_pkg: shared FSM states and 8N1 frame constants for the UART endpoint
package serial_uart_endpoint_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;
  localparam int DATA_BITS = 8;
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
endpackage

// File: rtl/serial_uart_endpoint_byte_fifo.sv
// byte_fifo: first-word-fall-through byte FIFO; full blocks push, empty blocks pop
module byte_fifo
  import serial_uart_endpoint_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_data,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] head,
  output logic                 full,
  output logic                 empty
);
  localparam int PW = $clog2(DEPTH);
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0] count_q, count_d;
  logic push_ok, pop_ok;
  always_comb begin
    full = count_q == (PW+1)'(DEPTH);
    empty = count_q == '0;
    push_ok = push && !full;
    pop_ok = pop && !empty;
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    count_d = count_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    head = mem_q[rd_ptr_q];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/serial_uart_endpoint.sv
// serial_uart_endpoint: processor serial port bridged to an 8N1 UART through TX/RX byte FIFOs
module serial_uart_endpoint
  import serial_uart_endpoint_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  output logic       wr_ready,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       uart_txd,
  input  logic       uart_rxd,
  output logic       rx_overrun,
  output logic       rx_frame_err
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
  uart_state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [BW-1:0] tx_baud_q, tx_baud_d, rx_baud_q, rx_baud_d;
  logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic txd_q, txd_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic rx_s1_q, rx_s2_q, rx_prev_q;
  logic tx_pop, tx_full, tx_empty, tx_bit_end, rx_push, rx_full, rx_empty, rx_bit_end;
  logic [7:0] tx_head, rx_head;
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock(clock), .reset(reset), .push(wr_en), .push_data(wr_data), .pop(tx_pop),
    .head(tx_head), .full(tx_full), .empty(tx_empty)
  );
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock(clock), .reset(reset), .push(rx_push), .push_data(rx_shift_q), .pop(rd_en),
    .head(rx_head), .full(rx_full), .empty(rx_empty)
  );
  assign wr_ready = !tx_full;
  assign rd_valid = !rx_empty;
  assign rd_data = rd_valid ? rx_head : '0;
  assign uart_txd = txd_q;
  assign rx_overrun = overrun_q;
  assign rx_frame_err = frame_err_q;
  always_comb begin
    tx_state_d = tx_state_q;
    tx_bit_d = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop = 1'b0;
    tx_bit_end = tx_baud_q == BAUD_LAST;
    tx_baud_d = (tx_state_q == ST_IDLE || tx_bit_end) ? '0 : tx_baud_q + BW'(1);
    case (tx_state_q)
      ST_IDLE: if (!tx_empty) begin
        tx_pop = 1'b1;
        tx_shift_d = tx_head;
        tx_state_d = ST_START;
      end
      ST_START: if (tx_bit_end) begin
        tx_state_d = ST_DATA;
        tx_bit_d = '0;
      end
      ST_DATA: if (tx_bit_end) begin
        tx_shift_d = tx_shift_q >> 1;
        tx_bit_d = tx_bit_q + 3'd1;
        tx_state_d = tx_bit_q == LAST_BIT ? ST_STOP : ST_DATA;
      end
      ST_STOP: if (tx_bit_end) begin
        tx_pop = !tx_empty;
        tx_shift_d = tx_empty ? tx_shift_q : tx_head;
        tx_state_d = tx_empty ? ST_IDLE : ST_START;
      end
    endcase
    txd_d = (tx_state_d == ST_START) ? 1'b0 : (tx_state_d == ST_DATA) ? tx_shift_d[0] : 1'b1;
  end
  // rx_bit_q != LAST_BIT while in STOP marks waiting for the line to recover after a frame error
  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d = rx_baud_q;
    rx_bit_d = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push = 1'b0;
    overrun_d = overrun_q;
    frame_err_d = frame_err_q;
    rx_bit_end = rx_baud_q == BAUD_LAST;
    case (rx_state_q)
      ST_IDLE: if (rx_prev_q && !rx_s2_q) begin
        rx_state_d = ST_START;
        rx_baud_d = '0;
      end
      ST_START: if (rx_baud_q == BAUD_HALF) begin
        rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
        rx_baud_d = '0;
        rx_bit_d = '0;
      end else rx_baud_d = rx_baud_q + BW'(1);
      ST_DATA: if (rx_bit_end) begin
        rx_baud_d = '0;
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        rx_bit_d = rx_bit_q == LAST_BIT ? rx_bit_q : rx_bit_q + 3'd1;
        rx_state_d = rx_bit_q == LAST_BIT ? ST_STOP : ST_DATA;
      end else rx_baud_d = rx_baud_q + BW'(1);
      ST_STOP: if (!rx_bit_end) rx_baud_d = rx_baud_q + BW'(1);
      else if (rx_bit_q != LAST_BIT) rx_state_d = rx_s2_q ? ST_IDLE : ST_STOP;
      else if (rx_s2_q) begin
        rx_push = 1'b1;
        overrun_d = overrun_q | rx_full;
        rx_state_d = ST_IDLE;
      end else begin
        frame_err_d = 1'b1;
        rx_bit_d = '0;
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q <= ST_IDLE;
      tx_baud_q <= '0;
      tx_bit_q <= '0;
      tx_shift_q <= '0;
      txd_q <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_baud_q <= '0;
      rx_bit_q <= '0;
      rx_shift_q <= '0;
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_prev_q <= 1'b1;
      overrun_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_baud_q <= tx_baud_d;
      tx_bit_q <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q <= txd_d;
      rx_state_q <= rx_state_d;
      rx_baud_q <= rx_baud_d;
      rx_bit_q <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_s1_q <= uart_rxd;
      rx_s2_q <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      overrun_q <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end
endmodule

// File: tb/tb_serial_uart_endpoint.sv
// tb_serial_uart_endpoint: directed bench with TX line decoder and byte scoreboards
module tb_serial_uart_endpoint;
  localparam int C = 4;
  localparam int D = 16;
  logic clock = 1'b0, reset = 1'b1;
  logic [7:0] wr_data = '0;
  logic wr_en = 1'b0, rd_en = 1'b0, rxd_drv = 1'b1, lb = 1'b0;
  logic wr_ready, rd_valid, uart_txd, uart_rxd, rx_overrun, rx_frame_err;
  logic [7:0] rd_data;
  int n_tests = 0, n_fail = 0, cyc = 0, mon_idx = 0, mcnt = 0, base = 0;
  logic mact = 1'b0;
  logic [7:0] mbyte = '0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  int starts[$];
  logic [7:0] lbv[3] = '{8'h00, 8'hFF, 8'h3C};

  assign uart_rxd = lb ? uart_txd : rxd_drv;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  serial_uart_endpoint #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clock(clock), .reset(reset), .wr_data(wr_data), .wr_en(wr_en), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .uart_txd(uart_txd),
    .uart_rxd(uart_rxd), .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    return i == 0 ? 1'b0 : i == 9 ? 1'b1 : b[i-1];
  endfunction

  task automatic send_rx(input logic [7:0] b, input logic stop);
    for (int i = 0; i < 10; i++) begin
      rxd_drv = i == 9 ? stop : frame_bit(b, i);
      step(C);
    end
    rxd_drv = 1'b1;
  endtask

  task automatic wait_tx(input int lim);
    for (int k = 0; k < lim && mon_idx != tx_exp.size(); k++) step();
    check("tx_drain", mon_idx, tx_exp.size());
  endtask

  task automatic drain_rx(input string tag);
    while (rx_exp.size() > 0) begin
      check({tag, "_valid"}, rd_valid, 1);
      check({tag, "_data"}, rd_data, rx_exp.pop_front());
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
    end
    check({tag, "_empty"}, rd_valid, 0);
    check({tag, "_data_zero"}, rd_data, 0);
  endtask

  // Decodes every frame on uart_txd at bit centres and compares with the TX scoreboard
  always @(negedge clock) begin
    if (reset) mact = 1'b0;
    else if (!mact) begin
      if (!uart_txd) begin
        mact = 1'b1;
        mcnt = 0;
        starts.push_back(cyc);
      end
    end else begin
      mcnt++;
      if (mcnt % C == C / 2) begin
        if (mcnt / C == 0) check("tx_start_bit", uart_txd, 0);
        else if (mcnt / C == 9) check("tx_stop_bit", uart_txd, 1);
        else mbyte[mcnt/C-1] = uart_txd;
      end
      if (mcnt == 10 * C - 1) begin
        mact = 1'b0;
        check("tx_frame_expected", mon_idx < tx_exp.size(), 1);
        if (mon_idx < tx_exp.size()) begin
          check("tx_byte", mbyte, tx_exp[mon_idx]);
          mon_idx++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(2);
    check("rst_txd", uart_txd, 1);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_overrun", rx_overrun, 0);
    check("rst_frame_err", rx_frame_err, 0);
    reset = 1'b0;
    step(2);
    wr_data = 8'hA5;
    wr_en = 1'b1;
    tx_exp.push_back(8'hA5);
    step();
    wr_en = 1'b0;
    check("a5_n1_idle", uart_txd, 1);
    step();
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < C; j++) begin
        check("a5_bit", uart_txd, frame_bit(8'hA5, i));
        step();
      end
    check("a5_after_idle", uart_txd, 1);
    wait_tx(20);
    step(5);
    base = starts.size();
    for (int i = 0; i < 20; i++) begin
      wr_data = 8'(i);
      wr_en = 1'b1;
      check("burst_wr_ready", wr_ready, i < 17);
      if (i < 17) tx_exp.push_back(8'(i));
      step();
    end
    wr_en = 1'b0;
    wait_tx(17 * 10 * C + 20);
    check("burst_frames", starts.size() - base, 17);
    for (int k = base + 1; k < starts.size(); k++) check("burst_gap", starts[k] - starts[k-1], 10 * C);
    step(5);
    lb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_data = lbv[i];
      wr_en = 1'b1;
      tx_exp.push_back(lbv[i]);
      rx_exp.push_back(lbv[i]);
      step();
    end
    wr_en = 1'b0;
    wait_tx(3 * 10 * C + 20);
    step(8);
    drain_rx("loop");
    lb = 1'b0;
    step(2);
    rxd_drv = 1'b0;
    step();
    rxd_drv = 1'b1;
    step(3 * C);
    check("glitch_rd_valid", rd_valid, 0);
    check("glitch_frame_err", rx_frame_err, 0);
    send_rx(8'h55, 1'b0);
    step(C);
    check("ferr_flag", rx_frame_err, 1);
    check("ferr_rd_valid", rd_valid, 0);
    check("ferr_overrun", rx_overrun, 0);
    send_rx(8'h96, 1'b1);
    rx_exp.push_back(8'h96);
    step(C);
    drain_rx("after_ferr");
    for (int i = 0; i < 17; i++) begin
      if (i < 16) rx_exp.push_back(8'(i * 37 + 5));
      send_rx(8'(i * 37 + 5), 1'b1);
      if (i == 15) begin
        step(C);
        check("ovr_before", rx_overrun, 0);
      end
    end
    step(C);
    check("ovr_flag", rx_overrun, 1);
    check("ovr_ferr_sticky", rx_frame_err, 1);
    drain_rx("ovr");
    rd_en = 1'b1;
    step(2);
    rd_en = 1'b0;
    check("empty_pop_valid", rd_valid, 0);
    send_rx(8'h5A, 1'b1);
    rx_exp.push_back(8'h5A);
    step(C);
    drain_rx("after_empty_pop");
    wr_data = 8'hC3;
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    step(3);
    check("mid_tx_start_low", uart_txd, 0);
    step(10);
    reset = 1'b1;
    step();
    check("mid_rst_txd", uart_txd, 1);
    check("mid_rst_wr_ready", wr_ready, 1);
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_overrun", rx_overrun, 0);
    check("mid_rst_frame_err", rx_frame_err, 0);
    reset = 1'b0;
    step(60);
    check("post_rst_idle", uart_txd, 1);
    check("post_rst_frames", mon_idx, tx_exp.size());
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
